cfu_issue: RTL and testbench

CPU-side initiator for the custom function unit (CFU) port. It accepts one decoded custom instruction from the execute stage, drives the CFU request lines, and holds the operands stable while the CFU stalls. It captures the result, adds a watchdog timeout, and returns the result to writeback over a valid/ready handshake. It sits between the pipeline's EX stage and the `cfu` block.

---
 rtl/cfu_pkg.sv | 16 +
 rtl/cfu_wdog.sv | 41 ++++
 rtl/cfu_issue.sv | 190 +++++++++++++++++++
 tb/tb_cfu_issue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU issue path: state encoding and field widths.
package cfu_pkg;

    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_W = 7;
    localparam int XLEN     = 32;
    localparam int REG_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } cfu_state_e;

endpackage

// File: rtl/cfu_wdog.sv
// Watchdog for the CFU wait phase. clr_i loads the budget, en_i counts it down,
// and expired_o goes high during the TIMEOUT_CYCLES-th enabled cycle after a clear.
// With TIMEOUT_CYCLES == 0 the watchdog is absent and never expires.
module cfu_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_i, clr_i, en_i};
            assign expired_o     = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            // Loading budget-1 makes the zero count coincide with the last allowed wait cycle.
            localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q;

            // Load on clear, count down while enabled, hold at zero once expired.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= LOAD_VAL;
                end else if (en_i && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            assign expired_o = (cnt_q == '0);
        end
    endgenerate

endmodule

// File: rtl/cfu_issue.sv
// CPU-side initiator for the custom function unit port: issues one decoded
// instruction, waits out CFU stalls under a watchdog, and hands the result to
// writeback over a valid/ready handshake.
module cfu_issue
    import cfu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [FUNCT3_W-1:0] req_funct3_i,
    input  logic [FUNCT7_W-1:0] req_funct7_i,
    input  logic [XLEN-1:0]     req_src1_i,
    input  logic [XLEN-1:0]     req_src2_i,
    input  logic [REG_W-1:0]    req_rd_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [XLEN-1:0]     rsp_rslt_o,
    output logic [REG_W-1:0]    rsp_rd_o,
    output logic                rsp_err_o,
    output logic                cfu_en_o,
    output logic [FUNCT3_W-1:0] cfu_funct3_o,
    output logic [FUNCT7_W-1:0] cfu_funct7_o,
    output logic [XLEN-1:0]     cfu_src1_o,
    output logic [XLEN-1:0]     cfu_src2_o,
    input  logic                cfu_stall_i,
    input  logic [XLEN-1:0]     cfu_rslt_i,
    output logic                busy_o,
    output logic [CNT_W-1:0]    busy_cycles_o
);

    cfu_state_e          state_q;
    logic                cfu_en_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [XLEN-1:0]     rsp_rslt_q;
    logic [REG_W-1:0]    rsp_rd_q;
    logic                busy_q;

    logic [FUNCT3_W-1:0] funct3_q;
    logic [FUNCT7_W-1:0] funct7_q;
    logic [XLEN-1:0]     src1_q;
    logic [XLEN-1:0]     src2_q;
    logic [REG_W-1:0]    rd_q;

    logic [CNT_W-1:0]    busy_cycles_q;
    logic [CNT_W-1:0]    busy_cycles_d;

    logic                accept;
    logic                wdog_expired;

    // Acceptance window: IDLE, or RESP while the current result drains. A CFU that
    // is still stalling (e.g. from an abandoned op) always blocks a new issue.
    always_comb begin
        req_ready_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: req_ready_o = !cfu_stall_i;
                ST_RESP: req_ready_o = rsp_ready_i && !cfu_stall_i;
                default: req_ready_o = 1'b0;
            endcase
        end
    end

    assign accept = req_valid_i && req_ready_o;

    cfu_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q == ST_ISSUE),
        .en_i     (state_q == ST_WAIT),
        .expired_o(wdog_expired)
    );

    // Request fields are captured on acceptance and held until the next one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            funct3_q <= '0;
            funct7_q <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            funct3_q <= req_funct3_i;
            funct7_q <= req_funct7_i;
            src1_q   <= req_src1_i;
            src2_q   <= req_src2_i;
            rd_q     <= req_rd_i;
        end
    end

    // Control FSM with registered strobes and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cfu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rslt_q  <= '0;
            rsp_rd_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            cfu_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_ISSUE;
                        cfu_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!cfu_stall_i) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rslt_q  <= cfu_rslt_i;
                        rsp_rd_q    <= rd_q;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A real result in the expiry cycle takes priority over the timeout.
                    if (!cfu_stall_i) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rslt_q  <= cfu_rslt_i;
                        rsp_rd_q    <= rd_q;
                        rsp_err_q   <= 1'b0;
                    end else if (wdog_expired) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rslt_q  <= '0;
                        rsp_rd_q    <= rd_q;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (accept) begin
                            state_q  <= ST_ISSUE;
                            cfu_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of cycles spent waiting on a stalled CFU.
    always_comb begin
        busy_cycles_d = busy_cycles_q;
        if ((state_q == ST_WAIT) && (busy_cycles_q != {CNT_W{1'b1}})) begin
            busy_cycles_d = busy_cycles_q + 1'b1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cycles_q <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign cfu_en_o      = cfu_en_q;
    assign cfu_funct3_o  = funct3_q;
    assign cfu_funct7_o  = funct7_q;
    assign cfu_src1_o    = src1_q;
    assign cfu_src2_o    = src2_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rslt_o    = rsp_rslt_q;
    assign rsp_rd_o      = rsp_rd_q;
    assign rsp_err_o     = rsp_err_q;
    assign busy_o        = busy_q;
    assign busy_cycles_o = busy_cycles_q;

endmodule

// File: tb/tb_cfu_issue.sv
// Directed bench for cfu_issue with a bench-driven CFU (result = src1 | src2).
module tb_cfu_issue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [6:0]  req_funct7_i;
    logic [31:0] req_src1_i;
    logic [31:0] req_src2_i;
    logic [4:0]  req_rd_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rslt_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_err_o;
    logic        cfu_en_o;
    logic [2:0]  cfu_funct3_o;
    logic [6:0]  cfu_funct7_o;
    logic [31:0] cfu_src1_o;
    logic [31:0] cfu_src2_o;
    logic        cfu_stall_i;
    logic [31:0] cfu_rslt_i;
    logic        busy_o;
    logic [31:0] busy_cycles_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cfu_issue #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_funct3_i (req_funct3_i),
        .req_funct7_i (req_funct7_i),
        .req_src1_i   (req_src1_i),
        .req_src2_i   (req_src2_i),
        .req_rd_i     (req_rd_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rslt_o   (rsp_rslt_o),
        .rsp_rd_o     (rsp_rd_o),
        .rsp_err_o    (rsp_err_o),
        .cfu_en_o     (cfu_en_o),
        .cfu_funct3_o (cfu_funct3_o),
        .cfu_funct7_o (cfu_funct7_o),
        .cfu_src1_o   (cfu_src1_o),
        .cfu_src2_o   (cfu_src2_o),
        .cfu_stall_i  (cfu_stall_i),
        .cfu_rslt_i   (cfu_rslt_i),
        .busy_o       (busy_o),
        .busy_cycles_o(busy_cycles_o)
    );

    // Behavioural CFU datapath: OR of the registered operands.
    assign cfu_rslt_i = cfu_src1_o | cfu_src2_o;

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [6:0] f7);
        req_valid_i  = 1'b1;
        req_src1_i   = s1;
        req_src2_i   = s2;
        req_rd_i     = rd;
        req_funct3_i = f3;
        req_funct7_i = f7;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0; cfu_stall_i = 1'b0;
        req_src1_i = '0; req_src2_i = '0; req_rd_i = '0; req_funct3_i = '0; req_funct7_i = '0;
        step(); step();
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready_o); end
        n_checks++; if ({cfu_en_o, rsp_valid_o, rsp_err_o, busy_o} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {cfu_en_o, rsp_valid_o, rsp_err_o, busy_o}); end
        n_checks++; if ({rsp_rslt_o, rsp_rd_o, cfu_src1_o, cfu_src2_o, cfu_funct3_o, cfu_funct7_o} !== '0) begin n_fail++; $display("FAIL reset_data: got rslt=%h rd=%h src1=%h src2=%h expected all 0", rsp_rslt_o, rsp_rd_o, cfu_src1_o, cfu_src2_o); end
        n_checks++; if (busy_cycles_o !== 32'd0) begin n_fail++; $display("FAIL reset_busy_cycles: got %0d expected 0", busy_cycles_o); end
        rst_i = 1'b0;
        step();
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", req_ready_o); end
        $display("txn reset: done");
    endtask

    task automatic test_zero_latency();
        present(32'h0F00, 32'h00F0, 5'd5, 3'd1, 7'h01);
        step();
        req_valid_i = 1'b0;
        n_checks++; if (cfu_en_o !== 1'b1) begin n_fail++; $display("FAIL zl_en: got %b expected 1", cfu_en_o); end
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL zl_early_valid: got %b expected 0", rsp_valid_o); end
        step();
        n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL zl_valid: got %b expected 1", rsp_valid_o); end
        n_checks++; if (rsp_rslt_o !== 32'h0FF0) begin n_fail++; $display("FAIL zl_rslt: got %h expected 00000ff0", rsp_rslt_o); end
        n_checks++; if ({rsp_rd_o, rsp_err_o} !== {5'd5, 1'b0}) begin n_fail++; $display("FAIL zl_rd_err: got rd=%0d err=%b expected rd=5 err=0", rsp_rd_o, rsp_err_o); end
        n_checks++; if (cfu_en_o !== 1'b0) begin n_fail++; $display("FAIL zl_en_drop: got %b expected 0", cfu_en_o); end
        n_checks++; if (busy_cycles_o !== 32'd0) begin n_fail++; $display("FAIL zl_busy_cycles: got %0d expected 0", busy_cycles_o); end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        n_checks++; if ({rsp_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL zl_idle: got valid,busy=%b expected 00", {rsp_valid_o, busy_o}); end
        $display("txn zero_latency: rslt=%h rd=%0d", 32'h0FF0, 5);
    endtask

    task automatic test_stall3();
        present(32'h1234, 32'h00FF, 5'd7, 3'd2, 7'h11);
        step();
        req_valid_i = 1'b0;
        cfu_stall_i = 1'b1;
        n_checks++; if (cfu_en_o !== 1'b1) begin n_fail++; $display("FAIL s3_en: got %b expected 1", cfu_en_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (cfu_en_o !== 1'b0) begin n_fail++; $display("FAIL s3_en_wait%0d: got %b expected 0", i, cfu_en_o); end
            n_checks++; if ({cfu_src1_o, cfu_src2_o, cfu_funct3_o, cfu_funct7_o} !== {32'h1234, 32'h00FF, 3'd2, 7'h11}) begin
                n_fail++; $display("FAIL s3_operands%0d: got %h %h %h %h expected 00001234 000000ff 2 11", i, cfu_src1_o, cfu_src2_o, cfu_funct3_o, cfu_funct7_o);
            end
            n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL s3_early_valid%0d: got %b expected 0", i, rsp_valid_o); end
            if (i == 2) cfu_stall_i = 1'b0;
        end
        step();
        n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL s3_valid: got %b expected 1", rsp_valid_o); end
        n_checks++; if ({rsp_rslt_o, rsp_rd_o, rsp_err_o} !== {32'h12FF, 5'd7, 1'b0}) begin n_fail++; $display("FAIL s3_rsp: got %h rd=%0d err=%b expected 000012ff rd=7 err=0", rsp_rslt_o, rsp_rd_o, rsp_err_o); end
        n_checks++; if (busy_cycles_o !== 32'd3) begin n_fail++; $display("FAIL s3_busy_cycles: got %0d expected 3", busy_cycles_o); end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        $display("txn stall3: rslt=%h busy_cycles=%0d", 32'h12FF, 3);
    endtask

    task automatic test_back_to_back();
        rsp_ready_i = 1'b1;
        present(32'h1, 32'h2, 5'd1, 3'd0, 7'h00);
        step();
        present(32'h40, 32'h08, 5'd2, 3'd4, 7'h22);
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_issue_ready: got %b expected 0", req_ready_o); end
        step();
        n_checks++; if ({rsp_valid_o, rsp_rslt_o, rsp_rd_o} !== {1'b1, 32'h3, 5'd1}) begin n_fail++; $display("FAIL b2b_rsp1: got v=%b %h rd=%0d expected v=1 00000003 rd=1", rsp_valid_o, rsp_rslt_o, rsp_rd_o); end
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_resp_ready: got %b expected 1", req_ready_o); end
        step();
        req_valid_i = 1'b0;
        n_checks++; if ({cfu_en_o, rsp_valid_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_en2: got en,valid=%b expected 10", {cfu_en_o, rsp_valid_o}); end
        n_checks++; if (cfu_src1_o !== 32'h40) begin n_fail++; $display("FAIL b2b_src2: got %h expected 00000040", cfu_src1_o); end
        step();
        n_checks++; if ({rsp_valid_o, rsp_rslt_o, rsp_rd_o} !== {1'b1, 32'h48, 5'd2}) begin n_fail++; $display("FAIL b2b_rsp2: got v=%b %h rd=%0d expected v=1 00000048 rd=2", rsp_valid_o, rsp_rslt_o, rsp_rd_o); end
        step();
        rsp_ready_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", busy_o); end
        $display("txn back_to_back: rslt1=%h rslt2=%h", 32'h3, 32'h48);
    endtask

    task automatic test_backpressure();
        present(32'hA000, 32'h0005, 5'd9, 3'd3, 7'h05);
        step();
        present(32'hFFFF, 32'hFFFF, 5'd4, 3'd7, 7'h7F);
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({rsp_valid_o, rsp_rslt_o, rsp_rd_o, rsp_err_o} !== {1'b1, 32'hA005, 5'd9, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b %h rd=%0d err=%b expected v=1 0000a005 rd=9 err=0", i, rsp_valid_o, rsp_rslt_o, rsp_rd_o, rsp_err_o);
            end
            n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0", i, req_ready_o); end
            step();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        n_checks++; if ({rsp_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL bp_release: got valid,busy=%b expected 00", {rsp_valid_o, busy_o}); end
        $display("txn backpressure: rslt=%h held 4 cycles", 32'hA005);
    endtask

    task automatic test_timeout();
        present(32'h55, 32'hAA, 5'd3, 3'd5, 7'h33);
        step();
        req_valid_i = 1'b0;
        cfu_stall_i = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            step();
            n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL to_early_valid_t%0d: got %b expected 0", i, rsp_valid_o); end
        end
        step();
        n_checks++; if ({rsp_valid_o, rsp_err_o, rsp_rslt_o, rsp_rd_o} !== {1'b1, 1'b1, 32'h0, 5'd3}) begin
            n_fail++; $display("FAIL to_rsp: got v=%b err=%b %h rd=%0d expected v=1 err=1 00000000 rd=3", rsp_valid_o, rsp_err_o, rsp_rslt_o, rsp_rd_o);
        end
        n_checks++; if (busy_cycles_o !== 32'd11) begin n_fail++; $display("FAIL to_busy_cycles: got %0d expected 11", busy_cycles_o); end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        present(32'h1, 32'h1, 5'd6, 3'd0, 7'h00);
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL to_refuse: got %b expected 0", req_ready_o); end
        step();
        n_checks++; if ({busy_o, req_ready_o} !== 2'b00) begin n_fail++; $display("FAIL to_refuse_hold: got busy,ready=%b expected 00", {busy_o, req_ready_o}); end
        cfu_stall_i = 1'b0;
        #1;
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL to_ready_after_drop: got %b expected 1", req_ready_o); end
        req_valid_i = 1'b0;
        step();
        $display("txn timeout: err=1 rslt=0 rd=3");
    endtask

    task automatic test_expiry_race();
        present(32'h0300, 32'h0021, 5'd12, 3'd6, 7'h44);
        step();
        req_valid_i = 1'b0;
        cfu_stall_i = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            step();
            n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL race_early_valid_t%0d: got %b expected 0", i, rsp_valid_o); end
        end
        cfu_stall_i = 1'b0;
        step();
        n_checks++; if ({rsp_valid_o, rsp_err_o, rsp_rslt_o, rsp_rd_o} !== {1'b1, 1'b0, 32'h0321, 5'd12}) begin
            n_fail++; $display("FAIL race_rsp: got v=%b err=%b %h rd=%0d expected v=1 err=0 00000321 rd=12", rsp_valid_o, rsp_err_o, rsp_rslt_o, rsp_rd_o);
        end
        n_checks++; if (busy_cycles_o !== 32'd19) begin n_fail++; $display("FAIL race_busy_cycles: got %0d expected 19", busy_cycles_o); end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        $display("txn expiry_race: err=0 rslt=%h", 32'h0321);
    endtask

    task automatic test_reset_mid();
        int seen;
        present(32'hDEAD0000, 32'h0000BEEF, 5'd2, 3'd1, 7'h10);
        step();
        req_valid_i = 1'b0;
        cfu_stall_i = 1'b1;
        step();
        step();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rm_busy_wait: got %b expected 1", busy_o); end
        rst_i = 1'b1;
        step();
        n_checks++; if ({cfu_en_o, busy_o, rsp_valid_o, req_ready_o} !== 4'b0) begin n_fail++; $display("FAIL rm_flags: got en,busy,valid,ready=%b expected 0000", {cfu_en_o, busy_o, rsp_valid_o, req_ready_o}); end
        n_checks++; if ({cfu_src1_o, cfu_src2_o, rsp_rd_o, busy_cycles_o} !== '0) begin n_fail++; $display("FAIL rm_data: got src1=%h src2=%h rd=%0d bc=%0d expected all 0", cfu_src1_o, cfu_src2_o, rsp_rd_o, busy_cycles_o); end
        rst_i = 1'b0;
        step();
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rm_stall_block: got %b expected 0", req_ready_o); end
        cfu_stall_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid_o === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_response: got %0d valid cycles expected 0", seen); end
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b expected 1", req_ready_o); end
        $display("txn reset_mid: op dropped");
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_stall3();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_expiry_race();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
